// File: rtl/pll_lock_supervisor.sv
// ============================================================================
//  pll_lock_supervisor
//  Resets the PLL, qualifies its LOCK output and publishes clk_ok; retries on
//  lock timeout. Optional lock-loss counter enabled by PLL_LOSS_COUNT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
    parameter int RST_CYCLES     = 16,
    parameter int QUAL_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 98500,
    parameter int DROP_CYCLES    = 4,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             clk_ok,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retries,
    output logic [CNT_W-1:0] lost_count,
    output logic             fail
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int DW = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;

    localparam logic [1:0] S_RESET  = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_QUAL   = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] DROP_LAST = DW'(DROP_CYCLES - 1);
    localparam logic [31:0]   MAX_R     = 32'(MAX_RETRIES);

    logic             sync_meta;
    logic             lock_s;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    drop_cnt;
    logic [CNT_W-1:0] retries_inc;
    logic             timeout_evt;
    logic             loss_evt;

    // Two-flop synchroniser: the only consumer of the asynchronous LOCK input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync_meta <= pll_lock;
            lock_s    <= sync_meta;
        end
    end

    assign retries_inc = (retries == {CNT_W{1'b1}}) ? retries : retries + CNT_W'(1);
    assign timeout_evt = (state == S_WAIT) && !force_relock && !lock_s && (cnt == TO_LAST);
    assign loss_evt    = (state == S_LOCKED) && !force_relock && !lock_s && (drop_cnt == DROP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RESET;
            cnt      <= '0;
            drop_cnt <= '0;
            pll_rst  <= 1'b1;
            clk_ok   <= 1'b0;
            retries  <= '0;
            fail     <= 1'b0;
        end else if (force_relock) begin
            state    <= S_RESET;
            cnt      <= '0;
            drop_cnt <= '0;
            pll_rst  <= 1'b1;
            clk_ok   <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state <= S_QUAL;
                        cnt   <= '0;
                    end else if (timeout_evt) begin
                        state   <= S_RESET;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        retries <= retries_inc;
                        if (32'(retries_inc) >= MAX_R) begin
                            fail <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_QUAL: begin
                    // A dropout returns to WAIT with a fresh timeout window.
                    if (!lock_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == QUAL_LAST) begin
                        state    <= S_LOCKED;
                        cnt      <= '0;
                        drop_cnt <= '0;
                        clk_ok   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (lock_s) begin
                        drop_cnt <= '0;
                    end else if (loss_evt) begin
                        state    <= S_RESET;
                        cnt      <= '0;
                        drop_cnt <= '0;
                        clk_ok   <= 1'b0;
                        pll_rst  <= 1'b1;
                    end else begin
                        drop_cnt <= drop_cnt + DW'(1);
                    end
                end
            endcase
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_count <= '0;
        end else if (loss_evt && (lost_count != {CNT_W{1'b1}})) begin
            lost_count <= lost_count + CNT_W'(1);
        end
    end
`else
    assign lost_count = '0;
`endif

endmodule

`default_nettype wire
